// File: rtl/router_pkg.sv
// Shared router definitions: byte width default, packet FIFO write-FSM
// state encoding and the wrapping pointer increment.
package router_pkg;

  localparam int UWIDTH_DEF = 8;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_FILL = 2'd1,
    W_DROP = 2'd2
  } wstate_t;

  // Increment a slot pointer, wrapping from 'last' back to zero so that
  // non-power-of-two depths work.
  function automatic logic [7:0] ptr_inc_wrap(input logic [7:0] ptr,
                                              input logic [7:0] last);
    return (ptr == last) ? 8'd0 : ptr + 8'd1;
  endfunction

endpackage

// File: rtl/packet_fifo_mem.sv
// Packet slot storage: DEPTH slots of WIDTH bytes plus a per-slot
// last-byte index. Synchronous write, asynchronous read; contents are
// never cleared.
module packet_fifo_mem
  import router_pkg::*;
#(
  parameter int DEPTH     = 3,
  parameter int WIDTH     = 11,
  parameter int UWIDTH    = UWIDTH_DEF,
  parameter int PTR_SZ    = 2,
  parameter int PTR_IN_SZ = 4
) (
  input  logic                 clk,
  input  logic                 i_wr_en,
  input  logic [PTR_SZ-1:0]    i_waddr,
  input  logic [PTR_IN_SZ-1:0] i_widx,
  input  logic [UWIDTH-1:0]    i_wdata,
  input  logic                 i_len_en,
  input  logic [PTR_IN_SZ-1:0] i_len,
  input  logic [PTR_SZ-1:0]    i_raddr,
  input  logic [PTR_IN_SZ-1:0] i_ridx,
  output logic [UWIDTH-1:0]    o_rdata,
  output logic [PTR_IN_SZ-1:0] o_rlen
);

  logic [UWIDTH-1:0]    r_mem [DEPTH][WIDTH];
  logic [PTR_IN_SZ-1:0] r_len [DEPTH];

  // Byte and length writes on the rising edge
  always_ff @(posedge clk) begin
    if (i_wr_en) r_mem[i_waddr][i_widx] <= i_wdata;
    if (i_len_en) r_len[i_waddr] <= i_len;
  end

  assign o_rdata = r_mem[i_raddr][i_ridx];
  assign o_rlen  = r_len[i_raddr];

endmodule

// File: rtl/packet_fifo.sv
// Packet FIFO for router ports: whole packets become readable only once
// their last byte commits; over-length and aborted packets are dropped.
module packet_fifo
  import router_pkg::*;
#(
  parameter int DEPTH     = 3,
  parameter int WIDTH     = 11,
  parameter int UWIDTH    = UWIDTH_DEF,
  parameter int PTR_SZ    = 2,
  parameter int PTR_IN_SZ = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [UWIDTH-1:0] wr_data,
  input  logic              wr_last,
  input  logic              wr_abort,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [UWIDTH-1:0] rd_data,
  output logic              rd_last,
  output logic [PTR_SZ:0]   count,
  output logic              full,
  output logic              empty,
  output logic              drop
);

  localparam logic [PTR_SZ:0]    L_DEPTH     = (PTR_SZ+1)'(DEPTH);
  localparam logic [PTR_SZ-1:0]  L_LAST_SLOT = PTR_SZ'(DEPTH - 1);
  localparam logic [PTR_IN_SZ-1:0] L_LAST_IDX = PTR_IN_SZ'(WIDTH - 1);

  wstate_t              r_state;
  logic [PTR_SZ-1:0]    r_waddr, r_raddr;
  logic [PTR_IN_SZ-1:0] r_waddr_in, r_raddr_in;
  logic [PTR_SZ:0]      r_count;
  logic                 r_drop;

  logic                 w_wr_acc, w_abort, w_store, w_commit, w_release;
  logic [UWIDTH-1:0]    w_rdata;
  logic [PTR_IN_SZ-1:0] w_rlen;
  logic [PTR_SZ-1:0]    w_waddr_nxt, w_raddr_nxt;

  assign full  = (r_count == L_DEPTH);
  assign empty = (r_count == '0);
  assign count = r_count;
  assign drop  = r_drop;

  // A slot is only reserved once W_FILL is entered, so only W_IDLE can stall
  assign wr_ready = !rst && ((r_state == W_IDLE) ? !full : 1'b1);
  assign w_wr_acc = wr_valid && wr_ready;
  assign w_abort  = (r_state == W_FILL) && wr_abort;
  assign w_store  = w_wr_acc && !w_abort && (r_state != W_DROP);
  assign w_commit = w_store && wr_last;

  assign rd_valid  = !rst && !empty;
  assign rd_data   = w_rdata;
  assign rd_last   = (r_raddr_in == w_rlen);
  assign w_release = rd_valid && rd_ready && rd_last;

  assign w_waddr_nxt = PTR_SZ'(ptr_inc_wrap(8'(r_waddr), 8'(L_LAST_SLOT)));
  assign w_raddr_nxt = PTR_SZ'(ptr_inc_wrap(8'(r_raddr), 8'(L_LAST_SLOT)));

  packet_fifo_mem #(
    .DEPTH    (DEPTH),
    .WIDTH    (WIDTH),
    .UWIDTH   (UWIDTH),
    .PTR_SZ   (PTR_SZ),
    .PTR_IN_SZ(PTR_IN_SZ)
  ) u_mem (
    .clk     (clk),
    .i_wr_en (w_store),
    .i_waddr (r_waddr),
    .i_widx  (r_waddr_in),
    .i_wdata (wr_data),
    .i_len_en(w_commit),
    .i_len   (r_waddr_in),
    .i_raddr (r_raddr),
    .i_ridx  (r_raddr_in),
    .o_rdata (w_rdata),
    .o_rlen  (w_rlen)
  );

  // Write FSM: fill a slot, commit on last, drop on overflow or abort
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= W_IDLE;
      r_waddr    <= '0;
      r_waddr_in <= '0;
      r_drop     <= 1'b0;
    end else begin
      r_drop <= 1'b0;
      case (r_state)
        W_IDLE: begin
          if (w_store) begin
            if (wr_last) begin
              r_waddr <= w_waddr_nxt;
            end else begin
              r_waddr_in <= PTR_IN_SZ'(1);
              r_state    <= W_FILL;
            end
          end
        end
        W_FILL: begin
          if (w_abort) begin
            r_waddr_in <= '0;
            r_drop     <= 1'b1;
            r_state    <= W_IDLE;
          end else if (w_store) begin
            if (wr_last) begin
              r_waddr    <= w_waddr_nxt;
              r_waddr_in <= '0;
              r_state    <= W_IDLE;
            end else if (r_waddr_in == L_LAST_IDX) begin
              r_waddr_in <= '0;
              r_drop     <= 1'b1;
              r_state    <= W_DROP;
            end else begin
              r_waddr_in <= r_waddr_in + 1'b1;
            end
          end
        end
        W_DROP: begin
          if (w_wr_acc && wr_last) r_state <= W_IDLE;
        end
        default: r_state <= W_IDLE;
      endcase
    end
  end

  // Read pointers and committed-packet count
  always_ff @(posedge clk) begin
    if (rst) begin
      r_raddr    <= '0;
      r_raddr_in <= '0;
      r_count    <= '0;
    end else begin
      if (rd_valid && rd_ready) begin
        if (rd_last) begin
          r_raddr_in <= '0;
          r_raddr    <= w_raddr_nxt;
        end else begin
          r_raddr_in <= r_raddr_in + 1'b1;
        end
      end
      case ({w_commit, w_release})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  a_count_range: assert property (@(posedge clk) disable iff (rst) r_count <= L_DEPTH);

endmodule
